// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dumper.
// Defining REGDUMP_CHECKSUM_EN adds the trailing XOR checksum state.
package regdump_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W       = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
`ifdef REGDUMP_CHECKSUM_EN
    SEND = 3'd3,
    CSUM = 3'd4
`else
    SEND = 3'd3
`endif
  } state_t;
endpackage

// File: rtl/regfile_dumper.sv
// Walks a registered-read register file and streams every word over valid/ready.
// With REGDUMP_CHECKSUM_EN defined, an XOR checksum word (addr 0, last) follows the registers.
module regfile_dumper
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] index_r;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  // Dump sequencer: state, index and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      index_r    <= {ADDR_W{1'b0}};
`ifdef REGDUMP_CHECKSUM_EN
      csum_r     <= {DATA_W{1'b0}};
`endif
      rf_addr    <= {ADDR_W{1'b0}};
      dump_valid <= 1'b0;
      dump_data  <= {DATA_W{1'b0}};
      dump_addr  <= {ADDR_W{1'b0}};
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ADDR;
            index_r <= {ADDR_W{1'b0}};
            rf_addr <= {ADDR_W{1'b0}};
            busy    <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            csum_r  <= {DATA_W{1'b0}};
`endif
          end
        end
        ADDR: begin
          state_r <= WAIT;
        end
        WAIT: begin
          dump_data  <= rf_data;
          dump_addr  <= index_r;
          dump_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          dump_last  <= 1'b0;
`else
          dump_last  <= (index_r == LAST_IDX);
`endif
          state_r    <= SEND;
        end
        SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_r     <= csum_r ^ dump_data;
`endif
            if (index_r < LAST_IDX) begin
              index_r <= index_r + 5'd1;
              rf_addr <= index_r + 5'd1;
              state_r <= ADDR;
            end else begin
              rf_addr <= {ADDR_W{1'b0}};
`ifdef REGDUMP_CHECKSUM_EN
              // The checksum word folds in the final register being accepted now.
              dump_data  <= csum_r ^ dump_data;
              dump_addr  <= {ADDR_W{1'b0}};
              dump_valid <= 1'b1;
              dump_last  <= 1'b1;
              state_r    <= CSUM;
`else
              dump_last <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= IDLE;
`endif
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_r    <= IDLE;
          end
        end
`endif
        default: begin
          state_r    <= IDLE;
          rf_addr    <= {ADDR_W{1'b0}};
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Randomized self-checking bench for regfile_dumper against a queue-based dump model.
// Honours REGDUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dumper;
  localparam int NR = 32;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int NW = NR + 1;
`else
  localparam int NW = NR;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          dump_ready;
  logic [4:0]    rf_addr;
  logic [4:0]    dump_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] dump_data;
  logic          dump_valid;
  logic          dump_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NR];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected and observed words.
  logic [4:0]    ea[$], oa[$], sa[$];
  logic [DW-1:0] ed[$], od[$], sd[$];
  logic          el[$], ol[$], sv[$];
  int            og[$];
  int done_gap, busy_low, unstable, rfa_bad, timed_out, early_done;

  regfile_dumper #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_last(dump_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle registered read.
  always @(posedge clk) rf_data <= mem[rf_addr];

  task automatic preload_fixed();
    for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? 32'h0 : (32'h100 + 32'(i));
  endtask

  task automatic preload_random();
    for (int i = 0; i < NR; i++) mem[i] = $urandom();
  endtask

  task automatic build_model();
    logic [DW-1:0] x;
    x = '0;
    ea.delete(); ed.delete(); el.delete();
    for (int i = 0; i < NR; i++) begin
      ea.push_back(5'(i)); ed.push_back(mem[i]); el.push_back(1'b0); x ^= mem[i];
    end
`ifdef REGDUMP_CHECKSUM_EN
    ea.push_back(5'd0); ed.push_back(x); el.push_back(1'b1);
`else
    el[NR-1] = 1'b1;
`endif
  endtask

  // Drives one dump (called at a negedge) and records what the consumer sees.
  task automatic run_dump(input bit do_pulse, input int rdy_pct, input int stall_at,
                          input int poke_at, input bit restart);
    int cnt, since_x, stall_left;
    bit pv, last_x, pend;
    logic [DW-1:0] hd; logic [4:0] ha; logic hl;
    oa.delete(); od.delete(); ol.delete(); og.delete(); sa.delete(); sd.delete(); sv.delete();
    done_gap = -1; busy_low = 0; unstable = 0; rfa_bad = 0; timed_out = 0; early_done = 0;
    cnt = 0; since_x = 0; stall_left = 0; pv = 0; last_x = 0; pend = 0;
    hd = '0; ha = '0; hl = 1'b0;
    dump_ready = 1'b0;
    if (do_pulse) start = 1'b1;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      cnt++; start = 1'b0;
      if (pend) begin
        if (!dump_valid || dump_data !== hd || dump_addr !== ha || dump_last !== hl) unstable++;
        pend = 0;
      end
      if (last_x) since_x++;
      if (done) begin
        if (last_x) done_gap = since_x; else early_done++;
        if (restart) start = 1'b1;
        return;
      end
      if (!busy) busy_low++;
      if (dump_valid && !pv) begin
        og.push_back(cnt);
        if (stall_at >= 0 && oa.size() == stall_at) stall_left = 5;
        if (poke_at >= 0 && oa.size() == poke_at) start = 1'b1;
      end
      pv = dump_valid;
      if (dump_valid && oa.size() < NR && rf_addr !== dump_addr) rfa_bad++;
      if (stall_left > 0) begin
        dump_ready = 1'b0; stall_left--;
        sd.push_back(dump_data); sa.push_back(dump_addr); sv.push_back(dump_valid);
      end else begin
        dump_ready = ($urandom_range(99) < rdy_pct);
      end
      if (dump_valid && dump_ready) begin
        oa.push_back(dump_addr); od.push_back(dump_data); ol.push_back(dump_last);
        cnt = 0; pv = 0;
        if (dump_last) begin last_x = 1; since_x = 0; end
      end else if (dump_valid) begin
        hd = dump_data; ha = dump_addr; hl = dump_last; pend = 1;
      end
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dump_ready = 1'b0;
    preload_fixed();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dump_valid, dump_data, dump_addr, dump_last, busy, done, rf_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h a=%0d l=%b busy=%b done=%b rfa=%0d want all 0",
               dump_valid, dump_data, dump_addr, dump_last, busy, done, rf_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dump_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy=%b v=%b done=%b want 0 0 0", busy, dump_valid, done);
    end
  endtask

  task automatic test_basic_dump();
    preload_fixed(); build_model();
    run_dump(1'b1, 100, -1, -1, 1'b0);
    n_cmp++; if (timed_out != 0) begin n_bad++; $display("FAIL basic_timeout: got 1 want 0"); end
    n_cmp++; if (oa.size() != NW) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", oa.size(), NW); end
    for (int i = 0; i < NW && i < oa.size(); i++) begin
      n_cmp++;
      if (oa[i] !== ea[i] || od[i] !== ed[i] || ol[i] !== el[i]) begin
        n_bad++; $display("FAIL basic_word%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                          i, oa[i], od[i], ol[i], ea[i], ed[i], el[i]);
      end
    end
    for (int i = 0; i < NR && i < og.size(); i++) begin
      n_cmp++; if (og[i] != 3) begin n_bad++; $display("FAIL basic_latency%0d: got %0d want 3", i, og[i]); end
    end
    n_cmp++; if (done_gap != 1) begin n_bad++; $display("FAIL basic_done_gap: got %0d want 1", done_gap); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    n_cmp++;
    if (busy_low != 0 || rfa_bad != 0 || early_done != 0) begin
      n_bad++; $display("FAIL basic_flags: got busy_low=%0d rfa_bad=%0d early_done=%0d want 0 0 0",
                        busy_low, rfa_bad, early_done);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_single_cycle: got %b want 0", done); end
  endtask

  task automatic test_random_dump();
    for (int r = 0; r < 3; r++) begin
      preload_random(); build_model();
      run_dump(1'b1, 50, -1, -1, 1'b0);
      n_cmp++; if (oa.size() != NW || timed_out != 0) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d (timeout=%0d) want %0d", r, oa.size(), timed_out, NW);
      end
      for (int i = 0; i < NW && i < oa.size(); i++) begin
        n_cmp++;
        if (oa[i] !== ea[i] || od[i] !== ed[i] || ol[i] !== el[i]) begin
          n_bad++; $display("FAIL rand%0d_word%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                            r, i, oa[i], od[i], ol[i], ea[i], ed[i], el[i]);
        end
      end
      for (int i = 0; i < NR && i < og.size(); i++) begin
        n_cmp++; if (og[i] != 3) begin n_bad++; $display("FAIL rand%0d_latency%0d: got %0d want 3", r, i, og[i]); end
      end
      n_cmp++; if (unstable != 0 || done_gap != 1) begin
        n_bad++; $display("FAIL rand%0d_hold: got unstable=%0d done_gap=%0d want 0 1", r, unstable, done_gap);
      end
    end
  endtask

  task automatic test_stall();
    preload_fixed(); build_model();
    run_dump(1'b1, 100, 10, -1, 1'b0);
    n_cmp++; if (sd.size() != 5) begin n_bad++; $display("FAIL stall_samples: got %0d want 5", sd.size()); end
    for (int i = 0; i < sd.size(); i++) begin
      n_cmp++;
      if (sd[i] !== 32'h10A || sa[i] !== 5'd10 || sv[i] !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold%0d: got d=%h a=%0d v=%b want d=0000010a a=10 v=1", i, sd[i], sa[i], sv[i]);
      end
    end
    n_cmp++; if (oa.size() != NW || unstable != 0) begin
      n_bad++; $display("FAIL stall_count: got %0d unstable=%0d want %0d 0", oa.size(), unstable, NW);
    end
    for (int i = 0; i < NW && i < oa.size(); i++) begin
      n_cmp++;
      if (oa[i] !== ea[i] || od[i] !== ed[i] || ol[i] !== el[i]) begin
        n_bad++; $display("FAIL stall_word%0d: got a=%0d d=%h want a=%0d d=%h", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    preload_random(); build_model();
    run_dump(1'b1, 100, -1, 4, 1'b0);
    n_cmp++; if (oa.size() != NW || early_done != 0 || done_gap != 1) begin
      n_bad++; $display("FAIL ignore_count: got %0d early=%0d gap=%0d want %0d 0 1", oa.size(), early_done, done_gap, NW);
    end
    for (int i = 0; i < NW && i < oa.size(); i++) begin
      n_cmp++;
      if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
        n_bad++; $display("FAIL ignore_word%0d: got a=%0d d=%h want a=%0d d=%h", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bool_wait: begin end
    preload_fixed(); build_model();
    start = 1'b1; dump_ready = 1'b1;
    for (int g = 0; g < 400 && !(dump_valid && dump_addr == 5'd7); g++) begin
      @(negedge clk); start = 1'b0;
    end
    dump_ready = 1'b0;
    n_cmp++; if (!(dump_valid && dump_addr == 5'd7)) begin
      n_bad++; $display("FAIL rstmid_reach_word7: got v=%b a=%0d want v=1 a=7", dump_valid, dump_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dump_valid, dump_data, dump_addr, dump_last, busy, done, rf_addr} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got v=%b d=%h a=%0d l=%b busy=%b done=%b rfa=%0d want all 0",
                        dump_valid, dump_data, dump_addr, dump_last, busy, done, rf_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_no_done%0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    run_dump(1'b1, 100, -1, -1, 1'b0);
    n_cmp++; if (oa.size() != NW || og.size() == 0) begin
      n_bad++; $display("FAIL rstmid_restart_count: got %0d want %0d", oa.size(), NW);
    end else if (oa[0] !== 5'd0 || od[0] !== ed[0] || og[0] != 3) begin
      n_bad++; $display("FAIL rstmid_restart_first: got a=%0d d=%h lat=%0d want a=0 d=%h lat=3", oa[0], od[0], og[0], ed[0]);
    end
  endtask

  task automatic test_back_to_back();
    preload_random(); build_model();
    run_dump(1'b1, 100, -1, -1, 1'b1);
    n_cmp++; if (done_gap != 1) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 1", done_gap); end
    run_dump(1'b0, 100, -1, -1, 1'b0);
    n_cmp++; if (og.size() == 0 || og[0] != 3) begin
      n_bad++; $display("FAIL b2b_latency: got %0d want 3", (og.size() == 0) ? -1 : og[0]);
    end
    n_cmp++; if (oa.size() != NW || done_gap != 1) begin
      n_bad++; $display("FAIL b2b_count: got %0d gap=%0d want %0d 1", oa.size(), done_gap, NW);
    end
    for (int i = 0; i < NW && i < oa.size(); i++) begin
      n_cmp++;
      if (oa[i] !== ea[i] || od[i] !== ed[i] || ol[i] !== el[i]) begin
        n_bad++; $display("FAIL b2b_word%0d: got a=%0d d=%h want a=%0d d=%h", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_stall();
    test_start_ignored();
    test_random_dump();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
